pcie_rx_req_decoder: RTL and testbench

Receive-side TLP decoder between the PCIe core's TRN receive interface and the DMA application's register/completer logic. It parses incoming 64-bit TRN beats and accepts single-DW memory writes and reads that hit BAR0. Each accepted TLP becomes one request word in a 2-entry output buffer; every other TLP is discarded. The block drives `trn_rdst_rdy_n` so no beat is accepted when the buffer has no space.

---
 rtl/pcie_rx_req_decoder_if.sv | 41 ++++
 rtl/pcie_rx_req_decoder.sv | 177 +++++++++++++++++
 tb/tb_pcie_rx_req_decoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_rx_req_decoder_if.sv
// pcie_rx_req_decoder_if
//   Bundles the PCIe core TRN receive port and the decoded request port of
//   pcie_rx_req_decoder.
//   slave  : decoder side (consumes TRN beats, produces requests)
//   master : core/application side (produces TRN beats, consumes requests)
interface pcie_rx_req_decoder_if;
  // TRN receive side
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic [63:0] trn_rd;
  logic        trn_rrem_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rerrfwd_n;
  logic [6:0]  trn_rbar_hit_n;
  // decoded request side
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic [15:0] req_rid;
  logic [7:0]  req_tag;
  logic [3:0]  req_be;
  logic [15:0] drop_count;

  modport slave (
    input  trn_rsof_n, trn_reof_n, trn_rd, trn_rrem_n, trn_rsrc_rdy_n,
           trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n, req_ready,
    output trn_rdst_rdy_n, req_valid, req_is_write, req_addr, req_data,
           req_rid, req_tag, req_be, drop_count
  );

  modport master (
    output trn_rsof_n, trn_reof_n, trn_rd, trn_rrem_n, trn_rsrc_rdy_n,
           trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n, req_ready,
    input  trn_rdst_rdy_n, req_valid, req_is_write, req_addr, req_data,
           req_rid, req_tag, req_be, drop_count
  );
endinterface

// File: rtl/pcie_rx_req_decoder.sv
// pcie_rx_req_decoder
//   Parses 64-bit TRN receive beats and turns single-DW MWr/MRd TLPs that hit
//   an enabled BAR into request words held in a 2-entry FIFO. Every other TLP
//   is discarded and (optionally) counted.
// Ports:
//   trn_clk   : core user clock
//   trn_reset : synchronous active-high reset
//   bus       : pcie_rx_req_decoder_if.slave (TRN rx beats in, requests out)
// Parameters:
//   BAR_MASK  : BARs whose hit accepts a TLP (bit 0 = BAR0)
// Build option:
//   PCIE_RX_DROP_STATS_EN : when defined, drop_count is a saturating count of
//                           discarded TLPs; otherwise drop_count is tied to 0.
module pcie_rx_req_decoder #(
  parameter logic [6:0] BAR_MASK = 7'b0000001
) (
  input logic                   trn_clk,
  input logic                   trn_reset,
  pcie_rx_req_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HDR2, DATA4, DISCARD} state_t;

  typedef struct packed {
    logic        is_write;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [3:0]  be;
  } req_t;

  state_t      state_q, state_d;
  logic        drop_q;            // header already disqualifies this TLP
  logic        wr_q;              // fmt[1]: MWr
  logic        dw4_q;             // fmt[0]: 4DW header
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [3:0]  be_q;
  logic [9:0]  addr_q;            // 4DW MWr address held for the DATA4 beat

  req_t        fifo_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        rdy_n_q;

  logic        xfer, sof, eof, err, abort, hdr_ok, drop_now, good, pop;
  logic        push_c, drop_c;
  req_t        ent;

  assign xfer  = !bus.trn_rsrc_rdy_n && !rdy_n_q;
  assign sof   = !bus.trn_rsof_n;
  assign eof   = !bus.trn_reof_n;
  assign err   = !bus.trn_rerrfwd_n;
  // Discontinue is honoured whether or not a beat transfers.
  assign abort = !bus.trn_rsrc_dsc_n && (state_q != IDLE);

  // All four fmt codes are legal single-DW memory requests, so fmt needs no check.
  assign hdr_ok = (bus.trn_rd[60:56] == 5'd0) && (bus.trn_rd[41:32] == 10'd1) &&
                  (|(~bus.trn_rbar_hit_n & BAR_MASK)) && !err;
  assign drop_now = drop_q || err;
  // Final-beat shape: 3DW MWr needs both DWs, 4DW MWr must not end here.
  assign good = !drop_now && !(dw4_q && wr_q) && !(!dw4_q && wr_q && bus.trn_rrem_n);

  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    drop_c       = 1'b0;
    ent.is_write = wr_q;
    ent.addr     = addr_q;
    ent.data     = '0;
    ent.rid      = rid_q;
    ent.tag      = tag_q;
    ent.be       = be_q;
    case (state_q)
      IDLE: if (xfer && sof) begin
        if (eof) drop_c = 1'b1;            // single-beat TLP is malformed
        else     state_d = HDR2;
      end
      HDR2: if (xfer) begin
        ent.addr = dw4_q ? bus.trn_rd[11:2] : bus.trn_rd[43:34];
        ent.data = (wr_q && !dw4_q) ? bus.trn_rd[31:0] : 32'h0;
        if (eof) begin
          state_d = IDLE;
          push_c  = good;
          drop_c  = !good;
        end else begin
          state_d = (dw4_q && wr_q && !drop_now) ? DATA4 : DISCARD;
        end
      end
      DATA4: if (xfer) begin
        ent.data = bus.trn_rd[63:32];
        if (eof) begin
          state_d = IDLE;
          push_c  = !err;
          drop_c  = err;
        end else begin
          state_d = DISCARD;
        end
      end
      DISCARD: if (xfer && eof) begin
        state_d = IDLE;
        drop_c  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      push_c  = 1'b0;
      drop_c  = 1'b1;
    end
  end

  assign pop   = (cnt_q != 2'd0) && bus.req_ready;
  assign cnt_d = cnt_q + {1'b0, push_c} - {1'b0, pop};

  always_ff @(posedge trn_clk) begin
    if (trn_reset) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      wr_q      <= 1'b0;
      dw4_q     <= 1'b0;
      rid_q     <= '0;
      tag_q     <= '0;
      be_q      <= '0;
      addr_q    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      rdy_n_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && xfer && sof) begin
        wr_q   <= bus.trn_rd[62];
        dw4_q  <= bus.trn_rd[61];
        rid_q  <= bus.trn_rd[31:16];
        tag_q  <= bus.trn_rd[15:8];
        be_q   <= bus.trn_rd[3:0];
        drop_q <= !hdr_ok;
      end
      if (state_q == HDR2 && xfer) addr_q <= ent.addr;
      if (push_c) begin
        fifo_q[wr_ptr_q] <= ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q   <= cnt_d;
      // Back-pressure from the post-update occupancy so a full FIFO never sees a beat.
      rdy_n_q <= (cnt_d == 2'd2);
    end
  end

  assign bus.trn_rdst_rdy_n = rdy_n_q;
  assign bus.req_valid      = (cnt_q != 2'd0);
  assign bus.req_is_write   = fifo_q[rd_ptr_q].is_write;
  assign bus.req_addr       = fifo_q[rd_ptr_q].addr;
  assign bus.req_data       = fifo_q[rd_ptr_q].data;
  assign bus.req_rid        = fifo_q[rd_ptr_q].rid;
  assign bus.req_tag        = fifo_q[rd_ptr_q].tag;
  assign bus.req_be         = fifo_q[rd_ptr_q].be;

`ifdef PCIE_RX_DROP_STATS_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge trn_clk) begin
    if (trn_reset)                            drop_cnt_q <= '0;
    else if (drop_c && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign bus.drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop    = drop_c;
  assign bus.drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_pcie_rx_req_decoder.sv
// tb_pcie_rx_req_decoder
//   Directed-vector bench with a scoreboard: stimulus pushes hand-computed
//   request words into a queue, a negedge monitor pops and compares each
//   request the DUT hands over.
module tb_pcie_rx_req_decoder;

  localparam int        BOUND = 200;
  localparam logic [6:0] BAR0 = 7'b1111110;
  localparam logic [6:0] BAR1 = 7'b1111101;

  typedef struct packed {
    logic        w;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_rx_req_decoder_if bus();
  pcie_rx_req_decoder dut (.trn_clk(clk), .trn_reset(rst), .bus(bus));

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   drops = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_dc();
`ifdef PCIE_RX_DROP_STATS_EN
    return (drops > 65535) ? 16'hFFFF : drops[15:0];
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [127:0] req_out();
    return {57'h0, bus.req_is_write, bus.req_addr, bus.req_data, bus.req_rid,
            bus.req_tag, bus.req_be};
  endfunction

  // Monitor: compare every handed-over request against the scoreboard head.
  exp_t act_r, exp_r;
  always @(negedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) begin
      act_r = {bus.req_is_write, bus.req_addr, bus.req_data, bus.req_rid,
               bus.req_tag, bus.req_be};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_req: got %h expected none", act_r);
      end else begin
        exp_r = sb.pop_front();
        if (act_r !== exp_r) begin
          n_bad++;
          $display("FAIL req: got %h expected %h", act_r, exp_r);
        end
      end
    end
  end

  // Tasks are entered and left one time unit after a rising edge.
  task automatic idle(input int n);
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_dsc_n = 1'b1;
    bus.trn_rerrfwd_n  = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic sof, input logic eof, input logic [63:0] d,
                      input logic rrem, input logic [6:0] bar, input logic err,
                      input logic dsc);
    int n;
    bus.trn_rsof_n     = !sof;
    bus.trn_reof_n     = !eof;
    bus.trn_rd         = d;
    bus.trn_rrem_n     = rrem;
    bus.trn_rbar_hit_n = bar;
    bus.trn_rerrfwd_n  = !err;
    bus.trn_rsrc_dsc_n = !dsc;
    bus.trn_rsrc_rdy_n = 1'b0;
    n = 0;
    while (bus.trn_rdst_rdy_n && n < BOUND) begin @(posedge clk); #1; n++; end
    if (n >= BOUND) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got rdst_rdy_n=1 for %0d cycles expected 0", n);
    end
    @(posedge clk); #1;
  endtask

  // 3DW MWr, length 1, BE=F; address 32-bit byte address.
  task automatic mwr3(input logic [7:0] tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [6:0] bar, input logic err);
    beat(1'b1, 1'b0, {32'h4000_0001, 16'h0100, tag, 8'h0F}, 1'b0, bar, 1'b0, 1'b0);
    beat(1'b0, 1'b1, {addr, data}, 1'b0, bar, err, 1'b0);
  endtask

  initial begin
    bus.req_ready      = 1'b1;
    bus.trn_rd         = '0;
    bus.trn_rrem_n     = 1'b0;
    bus.trn_rbar_hit_n = 7'h7F;
    idle(0);

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_rdy_n", bus.trn_rdst_rdy_n, 1);
    chk("rst_valid", bus.req_valid, 0);
    chk("rst_req",   req_out(), 0);
    chk("rst_drop",  bus.drop_count, 0);
    rst = 1'b0;
    idle(2);
    chk("post_rst_rdy_n", bus.trn_rdst_rdy_n, 0);

    // 3DW MWr: addr 0x10 -> DW 4
    sb.push_back('{1'b1, 10'h004, 32'hDEADBEEF, 16'h0100, 8'h05, 4'hF});
    beat(1'b1, 1'b0, {32'h4000_0001, 32'h0100_050F}, 1'b0, BAR0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, {32'h0000_0010, 32'hDEAD_BEEF}, 1'b0, BAR0, 1'b0, 1'b0);
    chk("latency_valid", bus.req_valid, 1);
    idle(2);
    chk("drop_mwr3", bus.drop_count, exp_dc());

    // 4DW MRd: addr 0xFFC -> DW 0x3FF
    sb.push_back('{1'b0, 10'h3FF, 32'h0, 16'h0200, 8'h07, 4'hF});
    beat(1'b1, 1'b0, {32'h2000_0001, 32'h0200_070F}, 1'b0, BAR0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, {32'h0000_0000, 32'h0000_0FFC}, 1'b0, BAR0, 1'b0, 1'b0);
    idle(2);
    chk("drop_mrd4", bus.drop_count, exp_dc());

    // Length-2 MWr goes through DISCARD
    beat(1'b1, 1'b0, {32'h4000_0002, 32'h0100_0A0F}, 1'b0, BAR0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, {32'h0000_0010, 32'h1111_1111}, 1'b0, BAR0, 1'b0, 1'b0);
    chk("discard_state", dut.state_q, 3);
    beat(1'b0, 1'b1, {32'h2222_2222, 32'h0}, 1'b0, BAR0, 1'b0, 1'b0);
    drops++;
    idle(2);
    chk("drop_len2", bus.drop_count, exp_dc());

    // BAR1-only hit
    mwr3(8'h0A, 32'h10, 32'h3333_3333, BAR1, 1'b0);
    drops++;
    idle(2);
    chk("drop_bar1", bus.drop_count, exp_dc());

    // Poisoned TLP
    mwr3(8'h0A, 32'h10, 32'h4444_4444, BAR0, 1'b1);
    drops++;
    idle(2);
    chk("drop_poison", bus.drop_count, exp_dc());

    // Backpressure: three MWr back-to-back while the consumer stalls
    bus.req_ready = 1'b0;
    sb.push_back('{1'b1, 10'h008, 32'hA1A1_A1A1, 16'h0100, 8'h01, 4'hF});
    sb.push_back('{1'b1, 10'h009, 32'hA2A2_A2A2, 16'h0100, 8'h02, 4'hF});
    sb.push_back('{1'b1, 10'h00A, 32'hA3A3_A3A3, 16'h0100, 8'h03, 4'hF});
    mwr3(8'h01, 32'h20, 32'hA1A1_A1A1, BAR0, 1'b0);
    chk("bp_rdy_after1", bus.trn_rdst_rdy_n, 0);
    mwr3(8'h02, 32'h24, 32'hA2A2_A2A2, BAR0, 1'b0);
    chk("bp_rdy_after2", bus.trn_rdst_rdy_n, 1);
    fork
      mwr3(8'h03, 32'h28, 32'hA3A3_A3A3, BAR0, 1'b0);
      begin
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_hold_rdy", bus.trn_rdst_rdy_n, 1);
        chk("bp_hold_head", req_out(),
            {57'h0, 1'b1, 10'h008, 32'hA1A1_A1A1, 16'h0100, 8'h01, 4'hF});
        bus.req_ready = 1'b1;
      end
    join
    idle(6);

    // Abort during HDR2 cancels the push
    beat(1'b1, 1'b0, {32'h4000_0001, 32'h0100_0B0F}, 1'b0, BAR0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, {32'h0000_0010, 32'h1234_5678}, 1'b0, BAR0, 1'b0, 1'b1);
    drops++;
    idle(2);
    chk("drop_abort", bus.drop_count, exp_dc());
    sb.push_back('{1'b1, 10'h00F, 32'hCAFE_F00D, 16'h0100, 8'h0C, 4'hF});
    mwr3(8'h0C, 32'h3C, 32'hCAFE_F00D, BAR0, 1'b0);
    idle(2);

`ifdef PCIE_RX_DROP_STATS_EN
    // Saturation: malformed single-beat TLPs
    for (int i = 0; i < 65537; i++)
      beat(1'b1, 1'b1, 64'h4000_0001_0100_000F, 1'b0, BAR0, 1'b0, 1'b0);
    drops += 65537;
    idle(2);
    chk("drop_sat", bus.drop_count, exp_dc());
`endif

    // Reset mid-TLP with a request pending
    bus.req_ready = 1'b0;
    sb.push_back('{1'b1, 10'h010, 32'h5555_5555, 16'h0100, 8'h0D, 4'hF});
    mwr3(8'h0D, 32'h40, 32'h5555_5555, BAR0, 1'b0);
    beat(1'b1, 1'b0, {32'h4000_0001, 32'h0100_0E0F}, 1'b0, BAR0, 1'b0, 1'b0);
    bus.trn_rsrc_rdy_n = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_rst_rdy_n", bus.trn_rdst_rdy_n, 1);
    chk("mid_rst_valid", bus.req_valid, 0);
    chk("mid_rst_req",   req_out(), 0);
    chk("mid_rst_drop",  bus.drop_count, 0);
    chk("mid_rst_state", dut.state_q, 0);
    sb.delete();
    drops = 0;
    rst = 1'b0;
    bus.req_ready = 1'b1;
    idle(1);
    beat(1'b0, 1'b1, {32'h0000_0044, 32'h6666_6666}, 1'b0, BAR0, 1'b0, 1'b0);
    idle(3);
    chk("trail_drop", bus.drop_count, 0);
    chk("trail_valid", bus.req_valid, 0);

    // 3DW MRd after reset: addr 0x124 -> DW 0x49, rrem_n=1 is fine for reads
    sb.push_back('{1'b0, 10'h049, 32'h0, 16'h0300, 8'h09, 4'h0});
    beat(1'b1, 1'b0, {32'h0000_0001, 32'h0300_09F0}, 1'b0, BAR0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, {32'h0000_0124, 32'h0}, 1'b1, BAR0, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < BOUND && sb.size() != 0; i++) begin @(posedge clk); #1; end
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
